// File: rtl/test_seq_pkg.sv
// Shared definitions for the board-test sequencer: FSM states and the
// per-test result codes reported to the on-screen updater.
package test_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PULSE    = 3'd1,
        WAIT_ACK = 3'd2,
        WAIT_RUN = 3'd3,
        RECORD   = 3'd4,
        FINISH   = 3'd5
    } state_e;

    localparam logic [1:0] PASS = 2'd1;
    localparam logic [1:0] FAIL = 2'd2;
    localparam logic [1:0] TOUT = 2'd3;

    // A timeout outranks whatever result line the test happened to leave behind
    function automatic logic [1:0] result_code(input logic timed, input logic passed);
        logic [1:0] code;
        if (timed) begin
            code = TOUT;
        end else if (passed) begin
            code = PASS;
        end else begin
            code = FAIL;
        end
        return code;
    endfunction

endpackage

// File: rtl/test_sequencer_sync2.sv
// Parameterised-width two-flop synchronizer with asynchronous reset,
// used to bring the self-test progress and result lines into clk.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two-stage capture of an asynchronous bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= {W{1'b0}};
            sync_q <= {W{1'b0}};
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/test_sequencer.sv
// Automatic board-test scheduler: runs each self-test in order and records pass/fail/timeout.
// Optional build macro TEST_SEQ_STOP_ON_FAIL_EN: end the sequence at the first fail or timeout.
module test_sequencer
    import test_seq_pkg::*;
#(
    parameter int NTESTS      = 4,
    parameter int INIT_CYCLES = 8,
    parameter int ACK_TIMEOUT = 1000,
    parameter int RUN_TW      = 28
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    output logic [NTESTS-1:0]         test_init,
    input  logic [NTESTS-1:0]         test_progress,
    input  logic [NTESTS-1:0]         test_result,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(NTESTS)-1:0] current,
    output logic [NTESTS-1:0]         pass_mask,
    output logic [NTESTS-1:0]         fail_mask,
    output logic [NTESTS-1:0]         tout_mask
);

    localparam int CW    = $clog2(NTESTS);
    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
    localparam int CNT_A = (RUN_TW > ACK_W) ? RUN_TW : ACK_W;
    localparam int CNT_W = (CNT_A > 8) ? CNT_A : 8;

    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LIMIT = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] RUN_LIMIT = CNT_W'((64'd1 << RUN_TW) - 64'd1);
    localparam logic [CW-1:0]    LAST_IDX  = CW'(NTESTS - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]     current_q, current_d;
    logic [NTESTS-1:0] pass_q, pass_d;
    logic [NTESTS-1:0] fail_q, fail_d;
    logic [NTESTS-1:0] tout_q, tout_d;
    logic              res_q, res_d;
    logic              timed_q, timed_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [NTESTS-1:0] prog_s;
    logic [NTESTS-1:0] res_s;
    logic [NTESTS-1:0] test_init_s;
    logic [1:0]        rec_code_s;

    sync2 #(.W(NTESTS)) u_prog_sync (
        .clk (clk),
        .rst (rst),
        .d   (test_progress),
        .q   (prog_s)
    );

    sync2 #(.W(NTESTS)) u_res_sync (
        .clk (clk),
        .rst (rst),
        .d   (test_result),
        .q   (res_s)
    );

    assign rec_code_s = result_code(timed_q, res_q);

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            current_q <= {CW{1'b0}};
            pass_q    <= {NTESTS{1'b0}};
            fail_q    <= {NTESTS{1'b0}};
            tout_q    <= {NTESTS{1'b0}};
            res_q     <= 1'b0;
            timed_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            current_q <= current_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            tout_q    <= tout_d;
            res_q     <= res_d;
            timed_q   <= timed_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        current_d = current_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        tout_d    = tout_q;
        res_d     = res_q;
        timed_d   = timed_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d   = PULSE;
                    cnt_d     = {CNT_W{1'b0}};
                    current_d = {CW{1'b0}};
                    pass_d    = {NTESTS{1'b0}};
                    fail_d    = {NTESTS{1'b0}};
                    tout_d    = {NTESTS{1'b0}};
                    res_d     = 1'b0;
                    timed_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            PULSE: begin
                if (cnt_q == INIT_LAST) begin
                    state_d = WAIT_ACK;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1'b1);
                end
            end
            WAIT_ACK: begin
                // A flag still high from an earlier run counts as the ack
                if (prog_s[current_q]) begin
                    state_d = WAIT_RUN;
                    cnt_d   = {CNT_W{1'b0}};
                    timed_d = 1'b0;
                end else if (cnt_q == ACK_LIMIT) begin
                    state_d            = RECORD;
                    tout_d[current_q]  = 1'b1;
                    timed_d            = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1'b1);
                end
            end
            WAIT_RUN: begin
                if (!prog_s[current_q]) begin
                    state_d = RECORD;
                    res_d   = res_s[current_q];
                    timed_d = 1'b0;
                end else if (cnt_q == RUN_LIMIT) begin
                    state_d            = RECORD;
                    tout_d[current_q]  = 1'b1;
                    timed_d            = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1'b1);
                end
            end
            RECORD: begin
                if (rec_code_s == PASS) begin
                    pass_d[current_q] = 1'b1;
                end else if (rec_code_s == FAIL) begin
                    fail_d[current_q] = 1'b1;
                end else begin
                    tout_d[current_q] = 1'b1;
                end
`ifdef TEST_SEQ_STOP_ON_FAIL_EN
                if ((rec_code_s != PASS) || (current_q == LAST_IDX)) begin
`else
                if (current_q == LAST_IDX) begin
`endif
                    state_d = FINISH;
                end else begin
                    state_d   = PULSE;
                    current_d = current_q + CW'(1'b1);
                    cnt_d     = {CNT_W{1'b0}};
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Abort drops the in-flight test: no mask bit is written for it
        if (abort && (state_q != IDLE) && (state_q != FINISH)) begin
            state_d = FINISH;
            pass_d  = pass_q;
            fail_d  = fail_q;
            tout_d  = tout_q;
        end else begin
            state_d = state_d;
        end
    end

    // Output decode; init is gated by abort in the same cycle
    always_comb begin
        test_init_s = {NTESTS{1'b0}};
        if ((state_q == PULSE) && !abort) begin
            test_init_s[current_q] = 1'b1;
        end else begin
            test_init_s = {NTESTS{1'b0}};
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
    end

    assign test_init = test_init_s;
    assign busy      = busy_q;
    assign done      = done_q;
    assign current   = current_q;
    assign pass_mask = pass_q;
    assign fail_mask = fail_q;
    assign tout_mask = tout_q;

endmodule

// File: doc/test_sequencer.md
Name: test_sequencer

Overview:
- Automatic board-test scheduler.
- On one start request it runs each self-test in turn: SRAM, SD, flash, SDRAM, and any others wired in.
- Per test: pulses the test's init line, waits for its in-progress flag to assert and then clear, and records pass, fail or timeout.
- Sits beside switch_mode in the test-board top level. Its init outputs are OR'd with the keyboard-driven inits, and its masks feed the updater for on-screen reporting.

Parameters:
- NTESTS, 4, number of sequenced tests; index 0 runs first.
- INIT_CYCLES, 8, cycles each init pulse is held high (1..255).
- ACK_TIMEOUT, 1000, max cycles from init release until progress must assert.
- RUN_TW, 28, width of the run-timeout counter; a run times out at 2^RUN_TW-1 cycles.

Ports:
- clk  in  1  system clock (clk7 domain).
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a full sequence.
- abort  in  1  one-cycle request to stop the sequence at once.
- test_init  out  NTESTS  per-test init pulse.
- test_progress  in  NTESTS  per-test in-progress flag, asynchronous to clk.
- test_result  in  NTESTS  per-test result, 1 = pass, valid once progress has fallen.
- busy  out  1  sequence running.
- done  out  1  one-cycle pulse when a sequence completes or is aborted.
- current  out  $clog2(NTESTS)  index of the test being run.
- pass_mask  out  NTESTS  tests that passed.
- fail_mask  out  NTESTS  tests that failed.
- tout_mask  out  NTESTS  tests that timed out.

Behaviour:
- Reset (asynchronous, active-high; all registers): state IDLE, all outputs 0, synchronizers cleared.
- Input synchronization:
  - test_progress and test_result each pass through a 2-flop synchronizer.
  - All decisions use the synchronized copies, so there is 2 cycles of input latency.
- States: IDLE, PULSE, WAIT_ACK, WAIT_RUN, RECORD, FINISH.
- IDLE:
  - start=1 clears all three masks, sets current=0 and busy=1, then goes to PULSE.
  - start while busy is ignored.
- PULSE:
  - test_init[current]=1 for exactly INIT_CYCLES cycles; all other init bits stay 0.
  - Then go to WAIT_ACK with the counter cleared.
- WAIT_ACK:
  - Synchronized progress[current]=1 -> WAIT_RUN, counter cleared.
  - If the counter reaches ACK_TIMEOUT first -> set tout_mask[current], go to RECORD.
- WAIT_RUN:
  - Synchronized progress[current]=0 -> RECORD, latching the synchronized result.
  - If the counter reaches all-ones first -> set tout_mask[current], go to RECORD.
- RECORD (one cycle):
  - If not timed out: set pass_mask[current] when the result is 1, otherwise set fail_mask[current].
  - Then either go to PULSE with current+1, or, if current==NTESTS-1, go to FINISH.
- FINISH (one cycle): done=1, busy=0 on the following cycle, return to IDLE.
- Mask exclusivity: exactly one of pass, fail or tout is set per completed test. Masks hold until the next start.
- abort in any non-IDLE state:
  - test_init is forced to 0 in the same cycle.
  - The next state is FINISH, so done pulses.
  - Masks keep the values of completed tests; the test being run gets no bit.
- Edge cases:
  - start and abort in the same cycle while in IDLE: abort wins and nothing starts.
  - A progress flag already high at PULSE entry (a stale run) is accepted as the ack.
  - current never exceeds NTESTS-1; there is no wrap-around.
- Latency: from start until test_init[0] rises is 1 cycle.

Optional Feature:
- Macro: TEST_SEQ_STOP_ON_FAIL_EN.
- Defined: a fail or timeout in RECORD goes directly to FINISH. Later tests are not run, and their mask bits stay 0.
- Undefined: all NTESTS tests always run, regardless of earlier failures.

Decomposition:
- Package test_seq_pkg holds:
  - the state enum (IDLE..FINISH);
  - the result-code constants PASS=2'd1, FAIL=2'd2, TOUT=2'd3, used by the updater.
- One natural sub-module: sync2, a parameterised-width 2-flop synchronizer with asynchronous reset. It is instantiated twice, once for progress and once for result.

Test Plan:
1. Pass path.
   - Stimulus: NTESTS=4, INIT_CYCLES=8. Each test model raises progress 5 cycles after its init falls, holds it for 100 cycles, and returns result=1.
   - Required response: pass_mask=4'b1111, fail=tout=0, exactly one done pulse, and each init is high for exactly 8 cycles, in order 0..3.
2. Fail path.
   - Stimulus: test 2 returns result=0.
   - Required response: pass_mask=4'b1011, fail_mask=4'b0100. With TEST_SEQ_STOP_ON_FAIL_EN defined: pass_mask=4'b0011, fail_mask=4'b0100, and test_init[3] never pulses.
3. Ack timeout.
   - Stimulus: test 1 never raises progress; ACK_TIMEOUT=1000.
   - Required response: tout_mask=4'b0010, and test 2's init begins about 1000 cycles after test 1's init fell.
4. Run timeout.
   - Stimulus: RUN_TW=8; test 3 holds progress high forever.
   - Required response: tout_mask[3]=1 after 255 cycles in WAIT_RUN, then done.
5. Abort.
   - Stimulus: abort while test 1 is in WAIT_RUN.
   - Required response: test_init=0 the same cycle, done pulses, pass_mask=4'b0001, and bit 1 is clear in all masks.
6. Reset and start corner cases.
   - Stimulus: assert rst asynchronously mid-PULSE. Separately, assert start while busy.
   - Required response: after rst, test_init=0 and the masks are 0 immediately, with no clock edge needed. The start while busy has no effect, and the sequence order is unchanged.
